// File: rtl/subgraph_scheduler.sv
// subgraph_scheduler: walks the node_info BRAM one entry at a time and presents
// each entry with its subgraph framing (node index, subgraph index, first/last)
// over a valid/ready interface.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start_i                         single-cycle start pulse (ignored while busy)
//   node_info_en_o/addr_o           BRAM read request
//   node_info_dout_i                BRAM data {row_length, num_of_nodes, source_node_flag}
//   row_length_o .. sg_last_o       per-entry output fields, qualified by valid_o
//   valid_o / ready_i               output handshake
//   done_o, busy_o, err_o           completion pulse, activity, sticky framing error
module subgraph_scheduler #(
  parameter int unsigned NODE_INFO_DEPTH = 13264,
  parameter int unsigned NUM_SUBGRAPHS   = 2708,
  parameter int unsigned ROW_LEN_WIDTH   = 11,
  parameter int unsigned NUM_NODE_WIDTH  = 8,
  parameter int unsigned BRAM_LATENCY    = 1,
  localparam int unsigned NODE_INFO_WIDTH = ROW_LEN_WIDTH + NUM_NODE_WIDTH + 1,
  localparam int unsigned ADDR_W = (NODE_INFO_DEPTH > 1) ? $clog2(NODE_INFO_DEPTH) : 1,
  localparam int unsigned SG_W   = (NUM_SUBGRAPHS > 1) ? $clog2(NUM_SUBGRAPHS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  output logic                       node_info_en_o,
  output logic [ADDR_W-1:0]          node_info_addr_o,
  input  logic [NODE_INFO_WIDTH-1:0] node_info_dout_i,
  output logic [ROW_LEN_WIDTH-1:0]   row_length_o,
  output logic [NUM_NODE_WIDTH-1:0]  num_of_nodes_o,
  output logic                       source_node_flag_o,
  output logic [NUM_NODE_WIDTH-1:0]  node_idx_o,
  output logic [SG_W-1:0]            sg_idx_o,
  output logic                       sg_first_o,
  output logic                       sg_last_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       done_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam logic [0:0] WAIT_LAST = 1'(BRAM_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, DONE} state_t;

  typedef struct packed {
    logic [ROW_LEN_WIDTH-1:0]  row_length;
    logic [NUM_NODE_WIDTH-1:0] num_of_nodes;
    logic                      source_node_flag;
  } node_info_t;

  state_t                    state, state_n;
  logic [0:0]                wait_q, wait_n;
  logic [ADDR_W-1:0]         addr_n;
  logic [SG_W-1:0]           sg_n;
  logic [NUM_NODE_WIDTH-1:0] node_n, num_n, eff_num;
  logic [ROW_LEN_WIDTH-1:0]  row_n;
  logic                      flag_n, first_n, last_n, err_n;
  logic                      at_head, terminate;
  node_info_t                din;

  assign din       = node_info_t'(node_info_dout_i);
  assign at_head   = (node_idx_o == '0);
  // A zero count at the head of a subgraph is treated as a single-entry subgraph
  assign eff_num   = at_head ? ((din.num_of_nodes == '0) ? NUM_NODE_WIDTH'(1) : din.num_of_nodes)
                             : num_of_nodes_o;
  // Stop on the last entry of the final subgraph or at the end of the table
  assign terminate = (sg_last_o && (sg_idx_o == SG_W'(NUM_SUBGRAPHS - 1))) ||
                     (node_info_addr_o == ADDR_W'(NODE_INFO_DEPTH - 1));

  // Next-state and next-register logic
  always_comb begin
    state_n = state;
    wait_n  = wait_q;
    addr_n  = node_info_addr_o;
    sg_n    = sg_idx_o;
    node_n  = node_idx_o;
    num_n   = num_of_nodes_o;
    row_n   = row_length_o;
    flag_n  = source_node_flag_o;
    first_n = sg_first_o;
    last_n  = sg_last_o;
    err_n   = err_o;

    case (state)
      IDLE: begin
        if (start_i) begin
          state_n = READ;
          addr_n  = '0;
          sg_n    = '0;
          node_n  = '0;
          err_n   = 1'b0;
        end
      end
      READ: begin
        state_n = WAIT;
        wait_n  = '0;
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          // Capture the BRAM word and its framing on the final wait edge
          state_n = OUT;
          row_n   = din.row_length;
          flag_n  = din.source_node_flag;
          num_n   = eff_num;
          first_n = at_head;
          last_n  = (node_idx_o == eff_num - NUM_NODE_WIDTH'(1));
          if ((at_head && (!din.source_node_flag || din.num_of_nodes == '0)) ||
              (!at_head && din.source_node_flag)) begin
            err_n = 1'b1;
          end
        end else begin
          wait_n = wait_q + 1'b1;
        end
      end
      OUT: begin
        if (ready_i) begin
          if (terminate) begin
            state_n = DONE;
          end else begin
            state_n = READ;
            addr_n  = node_info_addr_o + ADDR_W'(1);
            if (sg_last_o) begin
              node_n = '0;
              sg_n   = sg_idx_o + SG_W'(1);
            end else begin
              node_n = node_idx_o + NUM_NODE_WIDTH'(1);
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; status outputs follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      wait_q             <= '0;
      node_info_addr_o   <= '0;
      sg_idx_o           <= '0;
      node_idx_o         <= '0;
      num_of_nodes_o     <= '0;
      row_length_o       <= '0;
      source_node_flag_o <= 1'b0;
      sg_first_o         <= 1'b0;
      sg_last_o          <= 1'b0;
      err_o              <= 1'b0;
      node_info_en_o     <= 1'b0;
      valid_o            <= 1'b0;
      done_o             <= 1'b0;
      busy_o             <= 1'b0;
    end else begin
      state              <= state_n;
      wait_q             <= wait_n;
      node_info_addr_o   <= addr_n;
      sg_idx_o           <= sg_n;
      node_idx_o         <= node_n;
      num_of_nodes_o     <= num_n;
      row_length_o       <= row_n;
      source_node_flag_o <= flag_n;
      sg_first_o         <= first_n;
      sg_last_o          <= last_n;
      err_o              <= err_n;
      node_info_en_o     <= (state_n == READ);
      valid_o            <= (state_n == OUT);
      done_o             <= (state_n == DONE);
      busy_o             <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_subgraph_scheduler.sv
// Directed bench for subgraph_scheduler: three instances cover BRAM latency 1,
// latency 2 with multiple subgraphs, and a short table that ends on address.
module tb_subgraph_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected transfer table filled by each scenario
  int e_row[8], e_num[8], e_flag[8], e_node[8], e_sg[8], e_first[8], e_last[8], e_err[8];

  function automatic logic [19:0] ent(input int len, input int n, input int f);
    return {11'(len), 8'(n), 1'(f)};
  endfunction

  function automatic logic [46:0] pk(input int row, input int num, input int flag, input int node,
                                     input int sg, input int first, input int last, input int err);
    return {11'(row), 8'(num), 1'(flag), 8'(node), 16'(sg), 1'(first), 1'(last), 1'(err)};
  endfunction

  function automatic void set_exp(input int k, input int row, input int num, input int flag,
                                  input int node, input int sg, input int first, input int last,
                                  input int err);
    e_row[k] = row; e_num[k] = num; e_flag[k] = flag; e_node[k] = node;
    e_sg[k] = sg; e_first[k] = first; e_last[k] = last; e_err[k] = err;
  endfunction

  // ---------------- instance A: latency 1, one subgraph ----------------
  logic start_a = 0, ready_a = 0;
  logic en_a, valid_a, done_a, busy_a, err_a, flag_a, first_a, last_a;
  logic [3:0] addr_a;
  logic [19:0] dout_a;
  logic [10:0] row_a;
  logic [7:0] num_a, node_a;
  logic [0:0] sg_a;
  logic [19:0] mem_a [0:15];

  subgraph_scheduler #(.NODE_INFO_DEPTH(16), .NUM_SUBGRAPHS(1), .ROW_LEN_WIDTH(11),
                       .NUM_NODE_WIDTH(8), .BRAM_LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .node_info_en_o(en_a),
    .node_info_addr_o(addr_a), .node_info_dout_i(dout_a), .row_length_o(row_a),
    .num_of_nodes_o(num_a), .source_node_flag_o(flag_a), .node_idx_o(node_a),
    .sg_idx_o(sg_a), .sg_first_o(first_a), .sg_last_o(last_a), .valid_o(valid_a),
    .ready_i(ready_a), .done_o(done_a), .busy_o(busy_a), .err_o(err_a));

  always @(posedge clk) if (en_a) dout_a <= mem_a[addr_a];

  // ---------------- instance B: latency 2, four subgraphs ----------------
  logic start_b = 0, ready_b = 0;
  logic en_b, valid_b, done_b, busy_b, err_b, flag_b, first_b, last_b;
  logic [3:0] addr_b;
  logic [19:0] dout_b, pipe_b;
  logic [10:0] row_b;
  logic [7:0] num_b, node_b;
  logic [1:0] sg_b;
  logic [19:0] mem_b [0:15];

  subgraph_scheduler #(.NODE_INFO_DEPTH(16), .NUM_SUBGRAPHS(4), .ROW_LEN_WIDTH(11),
                       .NUM_NODE_WIDTH(8), .BRAM_LATENCY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .node_info_en_o(en_b),
    .node_info_addr_o(addr_b), .node_info_dout_i(dout_b), .row_length_o(row_b),
    .num_of_nodes_o(num_b), .source_node_flag_o(flag_b), .node_idx_o(node_b),
    .sg_idx_o(sg_b), .sg_first_o(first_b), .sg_last_o(last_b), .valid_o(valid_b),
    .ready_i(ready_b), .done_o(done_b), .busy_o(busy_b), .err_o(err_b));

  always @(posedge clk) begin
    if (en_b) pipe_b <= mem_b[addr_b];
    dout_b <= pipe_b;
  end

  // ---------------- instance C: depth 4, more subgraphs than entries ----------------
  logic start_c = 0, ready_c = 0;
  logic en_c, valid_c, done_c, busy_c, err_c, flag_c, first_c, last_c;
  logic [1:0] addr_c;
  logic [19:0] dout_c;
  logic [10:0] row_c;
  logic [7:0] num_c, node_c;
  logic [3:0] sg_c;
  logic [19:0] mem_c [0:3];
  int en_cnt_c = 0;

  subgraph_scheduler #(.NODE_INFO_DEPTH(4), .NUM_SUBGRAPHS(10), .ROW_LEN_WIDTH(11),
                       .NUM_NODE_WIDTH(8), .BRAM_LATENCY(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start_i(start_c), .node_info_en_o(en_c),
    .node_info_addr_o(addr_c), .node_info_dout_i(dout_c), .row_length_o(row_c),
    .num_of_nodes_o(num_c), .source_node_flag_o(flag_c), .node_idx_o(node_c),
    .sg_idx_o(sg_c), .sg_first_o(first_c), .sg_last_o(last_c), .valid_o(valid_c),
    .ready_i(ready_c), .done_o(done_c), .busy_o(busy_c), .err_o(err_c));

  always @(posedge clk) begin
    if (en_c) dout_c <= mem_c[addr_c];
    if (en_c) en_cnt_c <= en_cnt_c + 1;
  end

  function automatic logic [46:0] obs_a();
    return {row_a, num_a, flag_a, node_a, 16'(sg_a), first_a, last_a, err_a};
  endfunction
  function automatic logic [46:0] obs_b();
    return {row_b, num_b, flag_b, node_b, 16'(sg_b), first_b, last_b, err_b};
  endfunction
  function automatic logic [46:0] obs_c();
    return {row_c, num_c, flag_c, node_c, 16'(sg_c), first_c, last_c, err_c};
  endfunction

  // Start instance B and check n transfers against the expected table
  task automatic run_b(input int n, input bit hold, input bit poke);
    logic [46:0] snap;
    int k, cyc;
    ready_b = !hold;
    @(negedge clk) start_b = 1;
    @(negedge clk) start_b = 0;
    n_checks++;
    if (en_b !== 1'b1 || addr_b !== 4'd0 || err_b !== 1'b0) begin
      n_errors++; $display("FAIL b_read en=%b addr=%0d err=%b required en=1 addr=0 err=0", en_b, addr_b, err_b);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (valid_b !== 1'b0) begin
      n_errors++; $display("FAIL b_early_valid got %b required 0", valid_b);
    end
    @(negedge clk);
    n_checks++;
    if (valid_b !== 1'b1) begin
      n_errors++; $display("FAIL b_latency valid=%b required 1 at read+3", valid_b);
    end
    if (hold) begin
      snap = obs_b();
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        n_checks++;
        if (obs_b() !== snap || valid_b !== 1'b1 || en_b !== 1'b0) begin
          n_errors++;
          $display("FAIL b_hold cyc=%0d fields=%h valid=%b en=%b required fields=%h valid=1 en=0",
                   i, obs_b(), valid_b, en_b, snap);
        end
      end
      ready_b = 1;
    end
    k = 0;
    cyc = 0;
    while (k < n && cyc < 100) begin
      if (valid_b) begin
        n_checks++;
        if (obs_b() !== pk(e_row[k], e_num[k], e_flag[k], e_node[k], e_sg[k], e_first[k], e_last[k], e_err[k])) begin
          n_errors++;
          $display("FAIL b_xfer%0d got %h required %h", k, obs_b(),
                   pk(e_row[k], e_num[k], e_flag[k], e_node[k], e_sg[k], e_first[k], e_last[k], e_err[k]));
        end
        if (poke && k == 1) start_b = 1;
        k++;
      end
      @(negedge clk);
      start_b = 0;
      cyc++;
    end
    n_checks++;
    if (k != n) begin
      n_errors++; $display("FAIL b_count got %0d transfers required %0d", k, n);
    end
    n_checks++;
    if (done_b !== 1'b1) begin
      n_errors++; $display("FAIL b_done got %b required 1", done_b);
    end
    @(negedge clk);
    n_checks++;
    if (done_b !== 1'b0 || busy_b !== 1'b0) begin
      n_errors++; $display("FAIL b_idle done=%b busy=%b required 0 0", done_b, busy_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_b() !== 47'd0 || {valid_b, busy_b, done_b, en_b} !== 4'd0 || addr_b !== 4'd0) begin
      n_errors++; $display("FAIL reset_b fields=%h ctl=%b addr=%0d required all 0", obs_b(),
                           {valid_b, busy_b, done_b, en_b}, addr_b);
    end
    n_checks++;
    if (obs_a() !== 47'd0 || {valid_a, busy_a, done_a, en_a} !== 4'd0) begin
      n_errors++; $display("FAIL reset_a fields=%h ctl=%b required all 0", obs_a(), {valid_a, busy_a, done_a, en_a});
    end
    rst_n = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0 || en_b !== 1'b0) begin
      n_errors++; $display("FAIL reset_stay_idle busy=%b%b%b en_b=%b required 0", busy_a, busy_b, busy_c, en_b);
    end
  endtask

  task automatic test_basic();
    int k, cyc;
    mem_a[0] = ent(5, 3, 1);
    mem_a[1] = ent(2, 3, 0);
    mem_a[2] = ent(7, 3, 0);
    set_exp(0, 5, 3, 1, 0, 0, 1, 0, 0);
    set_exp(1, 2, 3, 0, 1, 0, 0, 0, 0);
    set_exp(2, 7, 3, 0, 2, 0, 0, 1, 0);
    ready_a = 1;
    @(negedge clk) start_a = 1;
    @(negedge clk) start_a = 0;
    n_checks++;
    if (en_a !== 1'b1 || busy_a !== 1'b1) begin
      n_errors++; $display("FAIL a_read en=%b busy=%b required 1 1", en_a, busy_a);
    end
    @(negedge clk);
    n_checks++;
    if (valid_a !== 1'b0 || en_a !== 1'b0) begin
      n_errors++; $display("FAIL a_wait valid=%b en=%b required 0 0", valid_a, en_a);
    end
    @(negedge clk);
    n_checks++;
    if (valid_a !== 1'b1) begin
      n_errors++; $display("FAIL a_latency valid=%b required 1 at read+2", valid_a);
    end
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 50) begin
      if (valid_a) begin
        n_checks++;
        if (obs_a() !== pk(e_row[k], e_num[k], e_flag[k], e_node[k], e_sg[k], e_first[k], e_last[k], e_err[k])) begin
          n_errors++;
          $display("FAIL a_xfer%0d got %h required %h", k, obs_a(),
                   pk(e_row[k], e_num[k], e_flag[k], e_node[k], e_sg[k], e_first[k], e_last[k], e_err[k]));
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (k != 3) begin
      n_errors++; $display("FAIL a_count got %0d transfers required 3", k);
    end
    n_checks++;
    if (done_a !== 1'b1 || valid_a !== 1'b0 || err_a !== 1'b0) begin
      n_errors++; $display("FAIL a_done done=%b valid=%b err=%b required 1 0 0", done_a, valid_a, err_a);
    end
    @(negedge clk);
    n_checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_errors++; $display("FAIL a_done_pulse done=%b busy=%b required 0 0", done_a, busy_a);
    end
  endtask

  // Latency 2, backpressure, flag=1 mid-subgraph, and N=0 head entry
  task automatic test_hold_and_error();
    mem_b[0] = ent(9, 2, 1);
    mem_b[1] = ent(4, 2, 1);
    mem_b[2] = ent(6, 0, 1);
    mem_b[3] = ent(1, 1, 1);
    mem_b[4] = ent(3, 1, 1);
    set_exp(0, 9, 2, 1, 0, 0, 1, 0, 0);
    set_exp(1, 4, 2, 1, 1, 0, 0, 1, 1);
    set_exp(2, 6, 1, 1, 0, 1, 1, 1, 1);
    set_exp(3, 1, 1, 1, 0, 2, 1, 1, 1);
    set_exp(4, 3, 1, 1, 0, 3, 1, 1, 1);
    run_b(5, 1'b1, 1'b0);
  endtask

  // Err cleared on start, N=0 head flags an error, start while busy ignored
  task automatic test_zero_count_and_busy_start();
    mem_b[0] = ent(6, 0, 1);
    mem_b[1] = ent(2, 1, 1);
    mem_b[2] = ent(3, 1, 1);
    mem_b[3] = ent(4, 1, 1);
    set_exp(0, 6, 1, 1, 0, 0, 1, 1, 1);
    set_exp(1, 2, 1, 1, 0, 1, 1, 1, 1);
    set_exp(2, 3, 1, 1, 0, 2, 1, 1, 1);
    set_exp(3, 4, 1, 1, 0, 3, 1, 1, 1);
    run_b(4, 1'b0, 1'b1);
  endtask

  task automatic test_depth_limit();
    int k, cyc, cnt0;
    for (int i = 0; i < 4; i++) mem_c[i] = ent(i + 1, 1, 1);
    ready_c = 1;
    cnt0 = en_cnt_c;
    @(negedge clk) start_c = 1;
    @(negedge clk) start_c = 0;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 60) begin
      if (valid_c) begin
        n_checks++;
        if (obs_c() !== pk(k + 1, 1, 1, 0, k, 1, 1, 0) || addr_c !== 2'(k)) begin
          n_errors++;
          $display("FAIL c_xfer%0d got %h addr=%0d required %h addr=%0d", k, obs_c(), addr_c,
                   pk(k + 1, 1, 1, 0, k, 1, 1, 0), k);
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (k != 4 || done_c !== 1'b1) begin
      n_errors++; $display("FAIL c_terminate transfers=%0d done=%b required 4 1", k, done_c);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (en_cnt_c - cnt0 != 4 || busy_c !== 1'b0 || addr_c !== 2'd3) begin
      n_errors++; $display("FAIL c_reads reads=%0d busy=%b addr=%0d required 4 0 3", en_cnt_c - cnt0, busy_c, addr_c);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    ready_b = 0;
    @(negedge clk) start_b = 1;
    @(negedge clk) start_b = 0;
    cyc = 0;
    while (!valid_b && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (valid_b !== 1'b1 || err_b !== 1'b1) begin
      n_errors++; $display("FAIL rm_reach_out valid=%b err=%b required 1 1", valid_b, err_b);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (valid_b !== 1'b0 || busy_b !== 1'b0 || err_b !== 1'b0 || obs_b() !== 47'd0) begin
      n_errors++; $display("FAIL rm_async valid=%b busy=%b err=%b fields=%h required all 0",
                           valid_b, busy_b, err_b, obs_b());
    end
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_b !== 1'b0 || en_b !== 1'b0 || valid_b !== 1'b0) begin
      n_errors++; $display("FAIL rm_idle busy=%b en=%b valid=%b required 0 0 0", busy_b, en_b, valid_b);
    end
    run_b(4, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    test_reset();
    test_basic();
    test_hold_and_error();
    test_zero_count_and_busy_start();
    test_depth_limit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/subgraph_scheduler.md
SUBGRAPH_SCHEDULER -- requirements
Module: subgraph_scheduler

Interface
REQ-001 SHALL have parameter NODE_INFO_DEPTH, default 13264, number of node_info entries to scan.
REQ-002 SHALL have parameter NUM_SUBGRAPHS, default 2708, subgraphs to emit before completion.
REQ-003 SHALL have parameter ROW_LEN_WIDTH, default 11, width of the row_length field.
REQ-004 SHALL have parameter NUM_NODE_WIDTH, default 8, width of the num_of_nodes field.
REQ-005 SHALL have parameter BRAM_LATENCY, default 1, node_info BRAM read latency in cycles (legal values 1, 2).
REQ-006 SHALL derive NODE_INFO_WIDTH = ROW_LEN_WIDTH+NUM_NODE_WIDTH+1, ADDR_W = $clog2(NODE_INFO_DEPTH), SG_W = $clog2(NUM_SUBGRAPHS).
REQ-007 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start_i, input, 1, single-cycle start pulse.
REQ-010 SHALL have ports node_info_en_o (output, 1, BRAM read enable) and node_info_addr_o (output, ADDR_W, BRAM read address).
REQ-011 SHALL have port node_info_dout_i, input, NODE_INFO_WIDTH, packed {row_length, num_of_nodes, source_node_flag}, flag at LSB.
REQ-012 SHALL have outputs row_length_o (ROW_LEN_WIDTH), num_of_nodes_o (NUM_NODE_WIDTH), source_node_flag_o (1), node_idx_o (NUM_NODE_WIDTH, index inside subgraph), sg_idx_o (SG_W, subgraph index), sg_first_o (1), sg_last_o (1).
REQ-013 SHALL have output valid_o (1) and input ready_i (1), valid/ready handshake for the output fields.
REQ-014 SHALL have outputs done_o (1, completion pulse), busy_o (1), err_o (1, sticky framing error).

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT, OUT, DONE.
REQ-016 IDLE: start_i=1 -> READ; clears address, sg_idx, node_idx and err_o.
REQ-017 READ: one cycle, node_info_en_o=1 with current address -> WAIT; node_info_en_o=0 in all other states.
REQ-018 WAIT: BRAM_LATENCY cycles; node_info_dout_i captured on the last WAIT edge -> OUT; valid_o asserts exactly BRAM_LATENCY+1 cycles after the READ cycle.
REQ-019 OUT: valid_o=1 and all output fields held stable until valid_o&&ready_i; ready_i SHALL NOT influence valid_o assertion.
REQ-020 On transfer SHALL advance address by 1 and node_idx by 1; if sg_last_o, node_idx -> 0 and sg_idx += 1; next state READ, or DONE when terminating.
REQ-021 SHALL terminate after transferring the entry with sg_last_o=1 and sg_idx_o=NUM_SUBGRAPHS-1, or the entry at address NODE_INFO_DEPTH-1, whichever first; address never wraps.
REQ-022 DONE: done_o=1 for exactly one cycle -> IDLE; busy_o=1 in every state except IDLE.
REQ-023 At node_idx=0, num_of_nodes from BRAM SHALL be latched; num_of_nodes_o presents the latched value for all entries of the subgraph.
REQ-024 sg_first_o SHALL equal (node_idx_o==0); sg_last_o SHALL equal (node_idx_o==latched num_of_nodes-1).
REQ-025 row_length_o and source_node_flag_o SHALL pass raw BRAM fields.
REQ-026 Framing error: flag=0 at node_idx=0, flag=1 at node_idx>0, or num_of_nodes=0 at node_idx=0 SHALL set err_o at the OUT entry; the entry is still emitted; err_o held until next start.
REQ-027 num_of_nodes=0 at node_idx=0 SHALL be treated as 1 (single-entry subgraph, sg_last_o=1).
REQ-028 start_i while busy_o=1 SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, valid_o=0, done_o=0, busy_o=0, err_o=0, node_info_en_o=0, node_info_addr_o=0, all data outputs 0, at any point including mid-transfer.
REQ-030 After rst_n deasserts, the block SHALL stay in IDLE until a fresh start_i.

Verification
REQ-031 BRAM_LATENCY=1, entries {len5,N3,f1},{len2,N3,f0},{len7,N3,f0}, NUM_SUBGRAPHS=1, ready_i=1 -> three transfers, node_idx 0,1,2, sg_first on first, sg_last on third, num_of_nodes_o=3 on all, done_o pulse one cycle after third transfer, err_o=0.
REQ-032 BRAM_LATENCY=2, one READ at cycle c -> valid_o first high at c+3; ready_i=0 for 5 cycles -> outputs stable, no new READ issued.
REQ-033 Second entry of a N=2 subgraph has flag=1 -> err_o=1 from that OUT onward, entry still emitted, err_o cleared on next start_i.
REQ-034 Entry {N=0,f1} -> emitted with sg_first_o=sg_last_o=1, err_o=1, sg_idx advances by 1.
REQ-035 NODE_INFO_DEPTH=4, NUM_SUBGRAPHS=10, all N=1 -> exactly 4 transfers, terminates after address 3, node_info_addr_o never exceeds 3.
REQ-036 rst_n asserted during OUT with valid_o=1 -> valid_o, busy_o low immediately; start_i pulsed during busy is ignored; start after reset restarts from address 0.
